// File: rtl/macguffin_round_ctrl.sv
// MacGuffin iterative round sequencer: one round per clock, subkeys from a synchronous RAM,
// external combinational round function F, shared datapath for encrypt and decrypt.
module macguffin_round_ctrl #(
    parameter int ROUNDS = 32,
    parameter int KEY_W  = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    input  logic             in_decrypt,
    output logic [4:0]       key_addr,
    input  logic [KEY_W-1:0] key_rdata,
    output logic [15:0]      rf_a,
    output logic [15:0]      rf_b,
    output logic [15:0]      rf_c,
    output logic [KEY_W-1:0] rf_key,
    input  logic [15:0]      rf_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             busy,
    output logic [4:0]       round_idx
);

    // state  | meaning
    // IDLE   | waiting for an input block, in_ready high
    // PRIME  | first subkey address presented, block untouched
    // ROUND  | one cipher round per cycle, key_addr runs one round ahead
    // DONE   | result held on out_data until out_ready
    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_ROUND,
        S_DONE
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(ROUNDS - 1);
    localparam logic [4:0] STEP_LIM = 5'(ROUNDS - 2);

    state_t      state, state_nxt;
    logic [63:0] blk, blk_nxt;
    logic        mode, mode_nxt;
    logic [4:0]  ridx_nxt;
    logic [4:0]  kaddr_nxt;
    logic [4:0]  kaddr_step;
    logic [15:0] x0, x1, x2, x3;

    assign x0 = blk[63:48];
    assign x1 = blk[47:32];
    assign x2 = blk[31:16];
    assign x3 = blk[15:0];

    // Decrypt walks the key schedule backwards and feeds F from the leading three words.
    assign kaddr_step = mode ? (key_addr - 5'd1) : (key_addr + 5'd1);
    assign rf_a       = mode ? x0 : x1;
    assign rf_b       = mode ? x1 : x2;
    assign rf_c       = mode ? x2 : x3;
    assign rf_key     = key_rdata;
    assign out_data   = blk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            blk       <= '0;
            mode      <= 1'b0;
            round_idx <= '0;
            key_addr  <= '0;
        end else begin
            state     <= state_nxt;
            blk       <= blk_nxt;
            mode      <= mode_nxt;
            round_idx <= ridx_nxt;
            key_addr  <= kaddr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        blk_nxt   = blk;
        mode_nxt  = mode;
        ridx_nxt  = round_idx;
        kaddr_nxt = key_addr;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    blk_nxt   = in_data;
                    mode_nxt  = in_decrypt;
                    ridx_nxt  = '0;
                    kaddr_nxt = in_decrypt ? LAST_IDX : 5'd0;
                    state_nxt = S_PRIME;
                end
            end
            S_PRIME: begin
                busy      = 1'b1;
                kaddr_nxt = kaddr_step;
                state_nxt = S_ROUND;
            end
            S_ROUND: begin
                busy     = 1'b1;
                blk_nxt  = mode ? {x3 ^ rf_out, x0, x1, x2} : {x1, x2, x3, x0 ^ rf_out};
                ridx_nxt = round_idx + 5'd1;
                // The address for the final round is already out; hold it there.
                if (round_idx < STEP_LIM)
                    kaddr_nxt = kaddr_step;
                if (round_idx == LAST_IDX)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_macguffin_round_ctrl.sv
// Directed bench for macguffin_round_ctrl: vector table plus hand-written handshake,
// key-address, reset and streaming sequences, with a key RAM and F stub in the bench.
module tb_macguffin_round_ctrl;
    localparam int ROUNDS = 32;

    logic        clk, rst;
    logic        in_valid, in_ready, in_decrypt;
    logic [63:0] in_data, out_data;
    logic [4:0]  key_addr, round_idx;
    logic [47:0] key_rdata, rf_key;
    logic [15:0] rf_a, rf_b, rf_c, rf_out;
    logic        out_valid, out_ready, busy;
    logic        stub;

    int n_checks = 0;
    int n_errors = 0;

    macguffin_round_ctrl #(.ROUNDS(ROUNDS), .KEY_W(48)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_decrypt(in_decrypt),
        .key_addr(key_addr), .key_rdata(key_rdata),
        .rf_a(rf_a), .rf_b(rf_b), .rf_c(rf_c), .rf_key(rf_key), .rf_out(rf_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .round_idx(round_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [47:0] key_of(input logic [4:0] i);
        logic [15:0] w;
        w = 16'(16'(i) * 16'h1111);
        return {w, w, w};
    endfunction

    always @(posedge clk) key_rdata <= key_of(key_addr);

    assign rf_out = stub ? (rf_a ^ rf_b ^ rf_c ^ rf_key[15:0]) : 16'h0000;

    // Reference cipher straight from the round equations.
    function automatic logic [63:0] model(input logic [63:0] p, input logic dec, input logic stb);
        logic [15:0] w0, w1, w2, w3, f, k;
        logic [63:0] b;
        b = p;
        for (int r = 0; r < ROUNDS; r++) begin
            {w0, w1, w2, w3} = b;
            k = key_of(dec ? 5'(ROUNDS - 1 - r) : 5'(r))[15:0];
            if (dec) begin
                f = stb ? (w0 ^ w1 ^ w2 ^ k) : 16'h0;
                b = {w3 ^ f, w0, w1, w2};
            end else begin
                f = stb ? (w1 ^ w2 ^ w3 ^ k) : 16'h0;
                b = {w1, w2, w3, w0 ^ f};
            end
        end
        return b;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [4:0] ka_q[$];
    always @(negedge clk) if (busy) ka_q.push_back(key_addr);

    task automatic start_op(input logic [63:0] d, input logic dec);
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_decrypt = dec;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic do_op(input logic [63:0] d, input logic dec, output logic [63:0] res, output int lat);
        start_op(d, dec);
        wait_done(lat);
        res = out_data;
        consume();
    endtask

    typedef struct {
        logic [63:0] din;
        logic        dec;
        logic        stb;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [63:0] res, c, p, d2;
        int lat, guard, outs, last_t, cyc;
        bit acc, acc_prev;
        logic [63:0] sb[$];
        logic [63:0] pats[5];

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_decrypt = 1'b0; out_ready = 1'b0; stub = 1'b0;
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_key_addr", 64'(key_addr), 64'd0);
        check("rst_round_idx", 64'(round_idx), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Vector table: F stubbed to zero gives identity after 32 rotations.
        vecs[0] = '{64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF};
        vecs[1] = '{64'hFFFF_0000_AAAA_5555, 1'b0, 1'b0, 64'hFFFF_0000_AAAA_5555};
        vecs[2] = '{64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF};
        vecs[3] = '{64'h0000_0000_0000_0000, 1'b0, 1'b1, 64'h0};
        vecs[4] = '{64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b1, 64'h0};
        vecs[5] = '{64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1'b1, 64'h0};
        for (int i = 3; i < 6; i++) vecs[i].exp = model(vecs[i].din, vecs[i].dec, vecs[i].stb);

        for (int i = 0; i < 6; i++) begin
            stub = vecs[i].stb;
            do_op(vecs[i].din, vecs[i].dec, res, lat);
            check($sformatf("vec%0d_data", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd34);
        end

        // Key address sequences.
        stub = 1'b0;
        ka_q.delete();
        do_op(64'h1111_2222_3333_4444, 1'b0, res, lat);
        check("enc_ka_len", 64'(ka_q.size()), 64'd33);
        for (int i = 0; i < 33 && i < ka_q.size(); i++)
            check($sformatf("enc_ka%0d", i), 64'(ka_q[i]), (i == 32) ? 64'd31 : 64'(i));
        ka_q.delete();
        do_op(64'h1111_2222_3333_4444, 1'b1, res, lat);
        check("dec_ka_len", 64'(ka_q.size()), 64'd33);
        for (int i = 0; i < 33 && i < ka_q.size(); i++)
            check($sformatf("dec_ka%0d", i), 64'(ka_q[i]), (i == 32) ? 64'd0 : 64'(31 - i));

        // Encrypt/decrypt round trip with the XOR F stub.
        stub = 1'b1;
        for (int i = 0; i < 100; i++) begin
            p = {$urandom(), $urandom()};
            do_op(p, 1'b0, c, lat);
            check("rt_enc", c, model(p, 1'b0, 1'b1));
            do_op(c, 1'b1, res, lat);
            check("rt_dec", res, p);
        end

        // Back-pressure in DONE with a pending input.
        stub = 1'b0;
        start_op(64'hA5A5_0F0F_1234_8765, 1'b0);
        wait_done(lat);
        in_valid = 1'b1; in_data = 64'h0BAD_F00D_0000_FFFF; in_decrypt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_data", out_data, 64'hA5A5_0F0F_1234_8765);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        consume();
        check("bp_idle_out_valid", 64'(out_valid), 64'd0);
        check("bp_idle_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_second_busy", 64'(busy), 64'd1);
        wait_done(lat);
        check("bp_second_data", out_data, 64'h0BAD_F00D_0000_FFFF);
        check("bp_second_latency", 64'(lat), 64'd34);
        consume();

        // Async reset in round 10.
        stub = 1'b1;
        start_op(64'h1357_9BDF_2468_ACE0, 1'b0);
        guard = 0;
        while (!(busy && round_idx == 5'd10) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("rst_reach_round10", 64'(round_idx), 64'd10);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_key_addr", 64'(key_addr), 64'd0);
        check("mid_rst_round_idx", 64'(round_idx), 64'd0);
        check("mid_rst_out_data", out_data, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        guard = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) guard++;
        end
        check("mid_rst_no_out", 64'(guard), 64'd0);
        d2 = 64'h7777_8888_9999_AAAA;
        do_op(d2, 1'b0, res, lat);
        check("post_rst_data", res, model(d2, 1'b0, 1'b1));
        check("post_rst_latency", 64'(lat), 64'd34);

        // Streaming with in_valid and out_ready held high.
        pats[0] = 64'h0001_0002_0003_0004;
        pats[1] = 64'hF0F0_E1E1_D2D2_C3C3;
        pats[2] = 64'h8000_0000_0000_0001;
        pats[3] = 64'h1234_5678_9ABC_DEF0;
        pats[4] = 64'h5555_AAAA_5555_AAAA;
        @(negedge clk);
        in_decrypt = 1'b0; in_data = pats[0]; in_valid = 1'b1; out_ready = 1'b1;
        outs = 0; last_t = 0; acc_prev = 1'b0; guard = 0;
        for (cyc = 0; cyc < 400 && outs < 4; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (acc_prev) begin
                guard++;
                in_data = pats[guard];
            end
            acc = in_valid && in_ready;
            if (acc) sb.push_back(model(in_data, 1'b0, 1'b1));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("stream_unexpected_out", out_data, 64'hx);
                else check($sformatf("stream_out%0d", outs), out_data, sb.pop_front());
                if (outs > 0) check("stream_interval", 64'(cyc - last_t), 64'd35);
                last_t = cyc;
                outs++;
            end
            acc_prev = acc;
        end
        check("stream_outs", 64'(outs), 64'd4);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        check("stream_sb_empty", 64'(sb.size()), 64'd0);
        check("stream_accepts", 64'(guard + (acc_prev ? 1 : 0)), 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
